// File: rtl/comparator_pulse_sequencer.sv
// comparator_pulse_sequencer
//
// Fires a burst of identical test pulses into a comparator channel group and
// checks the comparator response after each pulse. Each pulse is W cycles of
// pulse_en (W = max(pulse_width,1)), followed by bx_delay quiet cycles and a
// single READ cycle. In the READ cycle the halfstrip and compout results are
// captured and compared against their expected values. Halfstrips are
// compared only under the mask. Mismatches feed saturating error counters and
// a sticky per-bit error map.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   fire_pulse          start a burst (sampled only while idle)
//   abort               end the burst immediately, no readout
//   num_pulses          pulses per burst (0 = fire ignored)
//   pulse_width         pulse_en high cycles (0 behaves as 1)
//   bx_delay            quiet cycles between pulse_en fall and readout
//   compin_inject       drive compin while pulse_en is high
//   halfstrips*         comparator result, expected value, compare mask
//   compout*            comparator output and its expected value
//   errcnt_rst          clear error counters and error map
//   pulse_en, compin    pulser drive outputs
//   pulser_ready        high while idle
//   burst_done          one-cycle strobe when the last readout completes
//   pulse_count         readouts completed in the current/last burst
//   halfstrips_errcnt   readouts with a masked halfstrip mismatch
//   compout_errcnt      readouts with a compout mismatch
//   halfstrips_errmap   sticky OR of masked mismatching halfstrip bits
//   halfstrips_last     halfstrips captured at the last readout
//   compout_last        compout captured at the last readout
module comparator_pulse_sequencer #(
    parameter int NHS   = 32,
    parameter int CNT_W = 32,
    parameter int WID_W = 4,
    parameter int DLY_W = 3,
    parameter int NP_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fire_pulse,
    input  logic             abort,
    input  logic [NP_W-1:0]  num_pulses,
    input  logic [WID_W-1:0] pulse_width,
    input  logic [DLY_W-1:0] bx_delay,
    input  logic             compin_inject,
    input  logic [NHS-1:0]   halfstrips,
    input  logic [NHS-1:0]   halfstrips_expect,
    input  logic [NHS-1:0]   halfstrips_mask,
    input  logic             compout,
    input  logic             compout_expect,
    input  logic             errcnt_rst,
    output logic             pulse_en,
    output logic             compin,
    output logic             pulser_ready,
    output logic             burst_done,
    output logic [NP_W-1:0]  pulse_count,
    output logic [CNT_W-1:0] halfstrips_errcnt,
    output logic [CNT_W-1:0] compout_errcnt,
    output logic [NHS-1:0]   halfstrips_errmap,
    output logic [NHS-1:0]   halfstrips_last,
    output logic             compout_last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        READ = 2'd3
    } state_t;

    state_t state;

    // Burst configuration, frozen when the burst starts.
    logic [NP_W-1:0]  num_lat;
    logic [WID_W-1:0] wid_lat;
    logic [DLY_W-1:0] dly_lat;
    logic             inj_lat;

    // Down-counters holding the remaining cycles of ON / OFF minus one.
    logic [WID_W-1:0] on_cnt;
    logic [DLY_W-1:0] off_cnt;

    logic [NHS-1:0]   hs_diff;
    logic             hs_err;
    logic             co_err;
    logic [NP_W:0]    next_count;
    logic             more_pulses;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // ON length is max(w,1) cycles; the counter is loaded with length-1.
    function automatic logic [WID_W-1:0] on_load(input logic [WID_W-1:0] w);
        return (w == '0) ? '0 : w - WID_W'(1);
    endfunction

    always_comb begin
        hs_diff     = (halfstrips ^ halfstrips_expect) & halfstrips_mask;
        hs_err      = |hs_diff;
        co_err      = (compout != compout_expect);
        // One bit wider so the compare against num_lat cannot overflow.
        next_count  = {1'b0, pulse_count} + (NP_W + 1)'(1);
        more_pulses = (next_count < {1'b0, num_lat});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            num_lat           <= '0;
            wid_lat           <= '0;
            dly_lat           <= '0;
            inj_lat           <= 1'b0;
            on_cnt            <= '0;
            off_cnt           <= '0;
            pulse_en          <= 1'b0;
            compin            <= 1'b0;
            pulser_ready      <= 1'b1;
            burst_done        <= 1'b0;
            pulse_count       <= '0;
            halfstrips_errcnt <= '0;
            compout_errcnt    <= '0;
            halfstrips_errmap <= '0;
            halfstrips_last   <= '0;
            compout_last      <= 1'b0;
        end else begin
            burst_done <= 1'b0;

            if (abort && state != IDLE) begin
                // Abort drops the pulse without a readout; pulse_count holds.
                state        <= IDLE;
                pulse_en     <= 1'b0;
                compin       <= 1'b0;
                pulser_ready <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        pulser_ready <= 1'b1;
                        if (fire_pulse && num_pulses != '0) begin
                            num_lat      <= num_pulses;
                            wid_lat      <= pulse_width;
                            dly_lat      <= bx_delay;
                            inj_lat      <= compin_inject;
                            pulse_count  <= '0;
                            on_cnt       <= on_load(pulse_width);
                            pulse_en     <= 1'b1;
                            compin       <= compin_inject;
                            pulser_ready <= 1'b0;
                            state        <= ON;
                        end
                    end

                    ON: begin
                        if (on_cnt == '0) begin
                            pulse_en <= 1'b0;
                            compin   <= 1'b0;
                            if (dly_lat != '0) begin
                                off_cnt <= dly_lat - DLY_W'(1);
                                state   <= OFF;
                            end else begin
                                state   <= READ;
                            end
                        end else begin
                            on_cnt <= on_cnt - WID_W'(1);
                        end
                    end

                    OFF: begin
                        if (off_cnt == '0) begin
                            state <= READ;
                        end else begin
                            off_cnt <= off_cnt - DLY_W'(1);
                        end
                    end

                    READ: begin
                        halfstrips_last <= halfstrips;
                        compout_last    <= compout;
                        pulse_count     <= next_count[NP_W-1:0];
                        if (hs_err) begin
                            halfstrips_errcnt <= sat_inc(halfstrips_errcnt);
                            halfstrips_errmap <= halfstrips_errmap | hs_diff;
                        end
                        if (co_err) begin
                            compout_errcnt <= sat_inc(compout_errcnt);
                        end
                        if (more_pulses) begin
                            on_cnt   <= on_load(wid_lat);
                            pulse_en <= 1'b1;
                            compin   <= inj_lat;
                            state    <= ON;
                        end else begin
                            burst_done   <= 1'b1;
                            pulser_ready <= 1'b1;
                            state        <= IDLE;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end

            // Clearing the error state takes priority over a same-cycle
            // readout increment; the *_last capture above is unaffected.
            if (errcnt_rst) begin
                halfstrips_errcnt <= '0;
                compout_errcnt    <= '0;
                halfstrips_errmap <= '0;
            end
        end
    end

endmodule
